// File: rtl/i281_pkg.sv
// Shared sizes, dump FSM state encoding and write-decode helper for the i281 register file.
// Used by i281_register_file and i281_reg_dump_fsm.
package i281_pkg;

    localparam int I281_NUM_REGS  = 4;
    localparam int I281_REG_IDX_W = 2;

    localparam logic [I281_REG_IDX_W-1:0] I281_LAST_IDX = 2'd3;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_t;

    // One-hot write strobe per register; all zero when the write is not enabled.
    function automatic logic [I281_NUM_REGS-1:0] i281_write_decode(
        input logic                      en,
        input logic [I281_REG_IDX_W-1:0] sel
    );
        logic [I281_NUM_REGS-1:0] hit;
        hit = '0;
        if (en) begin
            hit[sel] = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/i281_reg_dump_fsm.sv
// Snapshot storage and IDLE/SEND valid-ready handshake that streams the four
// register values, one beat per accepted transfer, to the visualizer.
module i281_reg_dump_fsm
    import i281_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [I281_NUM_REGS-1:0][N-1:0]     regs,
    input  logic                                dump_start,
    input  logic                                dump_ready,
    output logic                                dump_valid,
    output logic [I281_REG_IDX_W-1:0]           dump_index,
    output logic [N-1:0]                        dump_data,
    output logic                                dump_busy
);

    dump_state_t                     state_reg, state_next;
    logic [I281_NUM_REGS-1:0][N-1:0] snap_reg, snap_next;
    logic [I281_REG_IDX_W-1:0]       index_reg, index_next;
    logic [N-1:0]                    data_reg, data_next;
    logic [I281_REG_IDX_W-1:0]       index_inc;

    assign index_inc = index_reg + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DUMP_IDLE;
            snap_reg  <= '0;
            index_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            snap_reg  <= snap_next;
            index_reg <= index_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        snap_next  = snap_reg;
        index_next = index_reg;
        data_next  = data_reg;
        case (state_reg)
            DUMP_IDLE: begin
                // regs carries the pre-edge values, so a same-edge write never leaks into the snapshot.
                if (dump_start) begin
                    snap_next  = regs;
                    index_next = '0;
                    data_next  = regs[0];
                    state_next = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                if (dump_ready) begin
                    if (index_reg == I281_LAST_IDX) begin
                        index_next = '0;
                        state_next = DUMP_IDLE;
                    end else begin
                        index_next = index_inc;
                        data_next  = snap_reg[index_inc];
                    end
                end
            end
            default: begin
                state_next = DUMP_IDLE;
            end
        endcase
    end

    assign dump_valid = (state_reg == DUMP_SEND);
    assign dump_busy  = (state_reg == DUMP_SEND);
    assign dump_index = index_reg;
    assign dump_data  = data_reg;

endmodule

// File: rtl/i281_register_file.sv
// i281 four-entry register file (A..D) with parallel operand outputs and snapshot dump port.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards WriteData to the selected output in the write cycle.
module i281_register_file
    import i281_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      WriteEnable,
    input  logic [I281_REG_IDX_W-1:0] WriteSelect,
    input  logic [N-1:0]              WriteData,
    output logic [N-1:0]              data0out,
    output logic [N-1:0]              data1out,
    output logic [N-1:0]              data2out,
    output logic [N-1:0]              data3out,
    input  logic                      DumpStart,
    input  logic                      DumpReady,
    output logic                      DumpValid,
    output logic [I281_REG_IDX_W-1:0] DumpIndex,
    output logic [N-1:0]              DumpData,
    output logic                      DumpBusy
);

    logic [N-1:0]                    reg_file_reg [I281_NUM_REGS];
    logic [I281_NUM_REGS-1:0][N-1:0] reg_bus;
    logic [I281_NUM_REGS-1:0][N-1:0] reg_view;
    logic [I281_NUM_REGS-1:0]        write_hit;

    assign write_hit = i281_write_decode(WriteEnable, WriteSelect);

    generate
        for (genvar gi = 0; gi < I281_NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    reg_file_reg[gi] <= '0;
                end else if (write_hit[gi]) begin
                    reg_file_reg[gi] <= WriteData;
                end
            end

            assign reg_bus[gi] = reg_file_reg[gi];

`ifdef REGFILE_WRITE_BYPASS_EN
            // Operand mux sees the writeback value in the same cycle it is written.
            assign reg_view[gi] = write_hit[gi] ? WriteData : reg_file_reg[gi];
`else
            assign reg_view[gi] = reg_file_reg[gi];
`endif
        end
    endgenerate

    assign data0out = reg_view[0];
    assign data1out = reg_view[1];
    assign data2out = reg_view[2];
    assign data3out = reg_view[3];

    i281_reg_dump_fsm #(
        .N(N)
    ) u_dump (
        .clk        (Clock),
        .rst        (Reset),
        .regs       (reg_bus),
        .dump_start (DumpStart),
        .dump_ready (DumpReady),
        .dump_valid (DumpValid),
        .dump_index (DumpIndex),
        .dump_data  (DumpData),
        .dump_busy  (DumpBusy)
    );

endmodule

// File: tb/tb_i281_register_file.sv
// Directed self-checking bench for i281_register_file: reset, writes, dumps with
// back-pressure, snapshot isolation, ignored restart and asynchronous abort.
module tb_i281_register_file;

    logic       Clock;
    logic       Reset;
    logic       WriteEnable;
    logic [1:0] WriteSelect;
    logic [7:0] WriteData;
    logic [7:0] data0out, data1out, data2out, data3out;
    logic       DumpStart;
    logic       DumpReady;
    logic       DumpValid;
    logic [1:0] DumpIndex;
    logic [7:0] DumpData;
    logic       DumpBusy;

    int compared;
    int mismatched;
    int beats;

    logic [7:0] exp_vals [4];

    i281_register_file #(.N(8)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .WriteEnable (WriteEnable),
        .WriteSelect (WriteSelect),
        .WriteData   (WriteData),
        .data0out    (data0out),
        .data1out    (data1out),
        .data2out    (data2out),
        .data3out    (data3out),
        .DumpStart   (DumpStart),
        .DumpReady   (DumpReady),
        .DumpValid   (DumpValid),
        .DumpIndex   (DumpIndex),
        .DumpData    (DumpData),
        .DumpBusy    (DumpBusy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [7:0] val);
        WriteEnable = 1'b1;
        WriteSelect = sel;
        WriteData   = val;
        step();
        WriteEnable = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [1:0] idx, input logic [7:0] val);
        $display("beat %s: valid=%0b index=%0d data=%0h", tag, DumpValid, DumpIndex, DumpData);
        check({tag, "_valid"}, {7'd0, DumpValid}, 8'd1);
        check({tag, "_index"}, {6'd0, DumpIndex}, {6'd0, idx});
        check({tag, "_data"},  DumpData, val);
    endtask

    task automatic check_idle(input string tag);
        $display("idle %s: valid=%0b busy=%0b index=%0d", tag, DumpValid, DumpBusy, DumpIndex);
        check({tag, "_valid"}, {7'd0, DumpValid}, 8'd0);
        check({tag, "_busy"},  {7'd0, DumpBusy},  8'd0);
        check({tag, "_index"}, {6'd0, DumpIndex}, 8'd0);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        beats       = 0;
        exp_vals[0] = 8'h11;
        exp_vals[1] = 8'h22;
        exp_vals[2] = 8'h33;
        exp_vals[3] = 8'h44;

        Reset       = 1'b0;
        WriteEnable = 1'b0;
        WriteSelect = 2'd0;
        WriteData   = 8'h00;
        DumpStart   = 1'b0;
        DumpReady   = 1'b0;
        #1 Reset = 1'b1;
        #11;

        // Reset state
        $display("reset: d0=%0h d1=%0h d2=%0h d3=%0h", data0out, data1out, data2out, data3out);
        check("rst_d0", data0out, 8'h00);
        check("rst_d1", data1out, 8'h00);
        check("rst_d2", data2out, 8'h00);
        check("rst_d3", data3out, 8'h00);
        check_idle("rst");
        Reset = 1'b0;

        // Single write to register C
        WriteEnable = 1'b1;
        WriteSelect = 2'd2;
        WriteData   = 8'hA5;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("wr_bypass_d2", data2out, 8'hA5);
`else
        check("wr_nobypass_d2", data2out, 8'h00);
`endif
        step();
        WriteEnable = 1'b0;
        $display("write C=A5: d0=%0h d1=%0h d2=%0h d3=%0h", data0out, data1out, data2out, data3out);
        check("wr_d2", data2out, 8'hA5);
        check("wr_d0", data0out, 8'h00);
        check("wr_d1", data1out, 8'h00);
        check("wr_d3", data3out, 8'h00);

        // Load 11,22,33,44 and dump with continuous ready
        for (int i = 0; i < 4; i++) write_reg(2'(i), exp_vals[i]);
        check("ld_d0", data0out, 8'h11);
        check("ld_d3", data3out, 8'h44);
        DumpReady = 1'b1;
        DumpStart = 1'b1;
        step();
        DumpStart = 1'b0;
        check_beat("d1_b0", 2'd0, 8'h11);
        check("d1_busy", {7'd0, DumpBusy}, 8'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            check_beat($sformatf("d1_b%0d", i), 2'(i), exp_vals[i]);
        end
        step();
        check_idle("d1_end");

        // Dump with back-pressure at beat 1
        DumpStart = 1'b1;
        step();
        DumpStart = 1'b0;
        check_beat("d2_b0", 2'd0, 8'h11);
        step();
        DumpReady = 1'b0;
        check_beat("d2_b1", 2'd1, 8'h22);
        for (int i = 0; i < 3; i++) begin
            step();
            check_beat($sformatf("d2_hold%0d", i), 2'd1, 8'h22);
        end
        DumpReady = 1'b1;
        step();
        check_beat("d2_b2", 2'd2, 8'h33);
        step();
        check_beat("d2_b3", 2'd3, 8'h44);
        step();
        check_idle("d2_end");

        // Same-edge write excluded from snapshot; DumpStart held through final transfer
        DumpStart   = 1'b1;
        WriteEnable = 1'b1;
        WriteSelect = 2'd0;
        WriteData   = 8'hFF;
        step();
        WriteEnable = 1'b0;
        check("d3_live_d0", data0out, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            if (DumpValid) beats++;
            if (i < 4) check_beat($sformatf("d3_b%0d", i), 2'(i), exp_vals[i]);
            if (i == 3) begin
                step();
                DumpStart = 1'b0;
            end else begin
                step();
            end
        end
        $display("d3 beats=%0d", beats);
        check("d3_beats", 8'(beats), 8'd4);
        check_idle("d3_end");

        // Asynchronous reset mid-dump at index 2
        DumpStart = 1'b1;
        step();
        DumpStart = 1'b0;
        check_beat("d4_b0", 2'd0, 8'hFF);
        step();
        step();
        check_beat("d4_b2", 2'd2, 8'h33);
        #2 Reset = 1'b1;
        #1;
        check_idle("d4_abort");
        check("d4_data", DumpData, 8'h00);
        check("d4_d0", data0out, 8'h00);
        check("d4_d1", data1out, 8'h00);
        check("d4_d2", data2out, 8'h00);
        check("d4_d3", data3out, 8'h00);
        Reset = 1'b0;
        step();
        check_idle("d4_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
